// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller and its digit decoder.
// Segment vectors are ordered {G,F,E,D,C,B,A}, active-high.
package seg7_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // True when digit idx and every more significant digit of val are zero.
    function automatic logic leading_zero(input logic [15:0] val, input logic [1:0] idx);
        logic [15:0] upper;
        upper = val >> {idx, 2'b00};
        return (idx != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// Combinational hex digit to 7-segment decoder, active-high {G,F,E,D,C,B,A}.
module hex7seg
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with dead-time blanking,
// frame-aligned data commit and optional leading-zero blanking.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned ON_CYC         = 1000,
    parameter int unsigned BLANK_CYC      = 50,
    parameter bit          EN_ACTIVE_LOW  = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        LOAD,
    input  logic        LZB,
    output logic        PENDING,
    output logic        FRAME,
    output logic        DS_EN1,
    output logic        DS_EN2,
    output logic        DS_EN3,
    output logic        DS_EN4,
    output logic        DS_A,
    output logic        DS_B,
    output logic        DS_C,
    output logic        DS_D,
    output logic        DS_E,
    output logic        DS_F,
    output logic        DS_G
);

    localparam int unsigned MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [3:0]       EN_IDLE    = {4{EN_ACTIVE_LOW}};
    localparam logic [6:0]       SEG_IDLE   = {7{SEG_ACTIVE_LOW}};

    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      active_q, active_d;
    logic             pending_q, pending_d;
    logic             frame_q, frame_d;
    logic [3:0]       en_q, en_d;
    logic [6:0]       seg_q, seg_d;

    logic             commit;
    logic [15:0]      active_shift;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_raw;
    logic [3:0]       en_raw;

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (dec_seg)
    );

    // Scan sequencing and frame boundary detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_d = 1'b1;
                        commit  = pending_q;
                    end
                end
            end
        endcase
    end

    // A LOAD coinciding with a commit leaves PENDING set for the new shadow value.
    always_comb begin
        shadow_d  = LOAD ? DATA : shadow_q;
        active_d  = commit ? shadow_q : active_q;
        pending_d = LOAD | (pending_q & ~commit);
    end

    // Outputs are computed from next state so the registered pins line up with the FSM.
    always_comb begin
        active_shift = active_q >> {idx_d, 2'b00};
        nibble       = active_shift[3:0];
        en_raw       = 4'b0000;
        seg_raw      = SEG_OFF;
        if (state_d == ST_ON) begin
            en_raw = 4'b0001 << idx_d;
            if (!(LZB && leading_zero(active_q, idx_d))) begin
                seg_raw = dec_seg;
            end
        end
        en_d  = en_raw ^ EN_IDLE;
        seg_d = seg_raw ^ SEG_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_BLANK;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= 16'h0000;
            active_q  <= 16'h0000;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            en_q      <= EN_IDLE;
            seg_q     <= SEG_IDLE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            en_q      <= en_d;
            seg_q     <= seg_d;
        end
    end

    assign PENDING = pending_q;
    assign FRAME   = frame_q;
    assign DS_EN1  = en_q[0];
    assign DS_EN2  = en_q[1];
    assign DS_EN3  = en_q[2];
    assign DS_EN4  = en_q[3];
    assign DS_A    = seg_q[0];
    assign DS_B    = seg_q[1];
    assign DS_C    = seg_q[2];
    assign DS_D    = seg_q[3];
    assign DS_E    = seg_q[4];
    assign DS_F    = seg_q[5];
    assign DS_G    = seg_q[6];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a normal-polarity and an inverted-polarity
// instance share all inputs and are checked against hand-written frame tables.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = 16'h0000;
    logic        load = 1'b0;
    logic        lzb = 1'b0;

    logic pend, frm, e1, e2, e3, e4, sa, sb, sc, sd, se, sf, sg;
    logic pend_i, frm_i, e1_i, e2_i, e3_i, e4_i, sa_i, sb_i, sc_i, sd_i, se_i, sf_i, sg_i;
    logic [3:0] en, en_i;
    logic [6:0] seg, seg_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected one-hot enable per position within a 16-cycle frame (position 0 = blank).
    logic [3:0] en_tab [0:16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};

    always #5 clk = ~clk;

    assign en    = {e4, e3, e2, e1};
    assign seg   = {sg, sf, se, sd, sc, sb, sa};
    assign en_i  = {e4_i, e3_i, e2_i, e1_i};
    assign seg_i = {sg_i, sf_i, se_i, sd_i, sc_i, sb_i, sa_i};

    seg7_scan_ctrl #(
        .ON_CYC         (3),
        .BLANK_CYC      (1),
        .EN_ACTIVE_LOW  (1'b0),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .CLK (clk), .RST (rst), .DATA (data), .LOAD (load), .LZB (lzb),
        .PENDING (pend), .FRAME (frm),
        .DS_EN1 (e1), .DS_EN2 (e2), .DS_EN3 (e3), .DS_EN4 (e4),
        .DS_A (sa), .DS_B (sb), .DS_C (sc), .DS_D (sd), .DS_E (se), .DS_F (sf), .DS_G (sg)
    );

    seg7_scan_ctrl #(
        .ON_CYC         (3),
        .BLANK_CYC      (1),
        .EN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut_inv (
        .CLK (clk), .RST (rst), .DATA (data), .LOAD (load), .LZB (lzb),
        .PENDING (pend_i), .FRAME (frm_i),
        .DS_EN1 (e1_i), .DS_EN2 (e2_i), .DS_EN3 (e3_i), .DS_EN4 (e4_i),
        .DS_A (sa_i), .DS_B (sb_i), .DS_C (sc_i), .DS_D (sd_i), .DS_E (se_i), .DS_F (sf_i),
        .DS_G (sg_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] ee, input logic [6:0] es,
                                 input logic ef, input logic ep);
        logic [3:0] ee_n;
        logic [6:0] es_n;
        logic [3:0] asserted;
        ee_n     = ~ee;
        es_n     = ~es;
        asserted = ~en_i;
        check({tag, "_en"}, en, ee);
        check({tag, "_seg"}, seg, es);
        check({tag, "_frame"}, frm, ef);
        check({tag, "_pending"}, pend, ep);
        check({tag, "_en_inv"}, en_i, ee_n);
        check({tag, "_seg_inv"}, seg_i, es_n);
        check({tag, "_frame_inv"}, frm_i, ef);
        check({tag, "_onehot_inv"}, ($countones(asserted) <= 1), 1);
    endtask

    // Runs frame positions 1..16 from a frame boundary, optionally strobing LOAD twice.
    task automatic check_frame(input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] s3, input logic [6:0] s4,
                               input logic ps, input logic pe,
                               input int lp1, input logic [15:0] d1,
                               input int lp2, input logic [15:0] d2);
        logic [6:0] sv [4];
        logic [3:0] ee;
        logic [6:0] es;
        logic       ep;
        sv = '{s1, s2, s3, s4};
        for (int p = 1; p <= 16; p++) begin
            step();
            ee = en_tab[p];
            es = (ee == 4'h0) ? 7'h00 : sv[(p - 1) / 4];
            if (p == 16)
                ep = pe;
            else if (lp1 > 0 && p > lp1)
                ep = 1'b1;
            else
                ep = ps;
            check_outputs("scan", ee, es, (p == 16), ep);
            if (p == lp1) begin
                load = 1'b1;
                data = d1;
            end else if (p == lp2) begin
                load = 1'b1;
                data = d2;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs("in_reset", 4'h0, 7'h00, 1'b0, 1'b0);
        rst = 1'b0;
        cyc = 0;
        check_outputs("cycle0", 4'h0, 7'h00, 1'b0, 1'b0);

        // Reset data, LOAD 12AF at cycle 2 which commits at cycle 16.
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 2, 16'h12AF, 0, 16'h0);
        // 12AF shown; 1111 then 2222 loaded, last wins.
        check_frame(7'h71, 7'h77, 7'h5B, 7'h06, 1'b0, 1'b0, 3, 16'h1111, 6, 16'h2222);
        // 2222 shown; 4321 loaded, then 0030 loaded coincident with the commit edge.
        check_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 1'b0, 1'b1, 2, 16'h4321, 15, 16'h0030);
        // 4321 shown while 0030 is still pending.
        check_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1, 1'b0, 0, 16'h0, 0, 16'h0);
        lzb = 1'b1;
        check_frame(7'h3F, 7'h4F, 7'h00, 7'h00, 1'b0, 1'b0, 2, 16'h0000, 0, 16'h0);
        check_frame(7'h3F, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 0, 16'h0, 0, 16'h0);

        // Reset while digit 3 is lit, with a value pending in the shadow.
        for (int p = 1; p <= 10; p++) begin
            step();
            load = (p == 2);
            if (p == 2) data = 16'h9999;
        end
        check("en3_lit", en, 4'h4);
        check("pending_before_rst", pend, 1'b1);
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", 4'h0, 7'h00, 1'b0, 1'b0);
        step();
        check_outputs("rst_held", 4'h0, 7'h00, 1'b0, 1'b0);
        lzb  = 1'b0;
        rst  = 1'b0;
        cyc  = 0;
        check_outputs("rst_release", 4'h0, 7'h00, 1'b0, 1'b0);
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 0, 16'h0, 0, 16'h0);
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 0, 16'h0, 0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 4-digit 7-segment display (DS_EN1..4, DS_A..G).
- Takes a 16-bit hex value over a load handshake and sequences the digit enables.
- Inserts a dead-time blank between digits to prevent ghosting.
- Commits new values only at frame boundaries so no frame shows mixed digits.
- Sits between application logic in top and the display pins.

Parameters:
ON_CYC, 1000, CLK cycles each digit is driven (>=1)
BLANK_CYC, 50, CLK cycles of all-enables-off dead time before each digit (>=1)
EN_ACTIVE_LOW, 0, 1 = DS_ENx asserted low
SEG_ACTIVE_LOW, 0, 1 = DS_A..G asserted low

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
DATA  in  16  value to show; DS_ENk displays DATA[4k-1:4k-4], so DS_EN4 is the most significant digit
LOAD  in  1  1-cycle strobe; captures DATA into the shadow register
LZB  in  1  leading-zero blanking enable (sampled live)
PENDING  out  1  shadow holds data not yet committed
FRAME  out  1  1-cycle pulse at each frame boundary
DS_EN1..DS_EN4  out  1 each  digit enables
DS_A..DS_G  out  1 each  segment drives

Behaviour:
- Reset (async, active-high; applies at any time, including mid-frame):
  - State = BLANK, digit index = 0, cycle counter = 0.
  - Shadow and active registers = 16'h0000; PENDING = 0; FRAME = 0.
  - All DS_ENx inactive; all segments inactive, per the polarity parameters.
- All outputs are registered.
- FSM states BLANK and ON:
  - BLANK: enables inactive, segments inactive, for exactly BLANK_CYC cycles, then go to ON.
  - ON: enable of the current digit active, segments = decode(active nibble), for exactly ON_CYC cycles, then go to BLANK with index = (index+1) mod 4.
  - One cycle counter, width clog2(max(ON_CYC, BLANK_CYC)), cleared on every state change.
- Timing:
  - After reset release, first cycle is cycle 0.
  - DS_EN1 is active on cycles BLANK_CYC .. BLANK_CYC+ON_CYC-1.
  - Frame period = 4*(BLANK_CYC+ON_CYC).
  - Exactly one enable is active at a time; never two.
- Frame boundary: the ON->BLANK transition leaving digit 4 (index 3).
  - On that edge FRAME = 1 for one cycle, during the first BLANK cycle.
  - If PENDING, active <= shadow and PENDING <= 0, so digit 1 of the next frame shows new data.
- LOAD:
  - Shadow <= DATA; PENDING <= 1 on the next edge.
  - Multiple LOADs within a frame: last one wins.
  - LOAD on the same cycle as a commit: commit takes the old shadow, shadow takes the new DATA, PENDING stays 1, so the new value commits at the following frame.
- Decode (segment bits {G,F,E,D,C,B,A}, active-high before the polarity parameter is applied):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking, when LZB = 1:
  - Digit k shows all segments inactive if its nibble and all higher nibbles are zero.
  - Digit 1 is never blanked.
  - The enable still follows the normal scan timing.
- Polarity parameters invert the corresponding outputs in every state, including reset.

Decomposition:
- Shared include file holds:
  - FSM state encodings (ST_BLANK, ST_ON).
  - Segment constants SEG_0..SEG_F.
  - SEG_OFF.
- One sub-module, hex7seg, is natural: a 4-bit in, 7-bit out combinational decoder, reused by other display blocks.
- Scan FSM, counters and shadow/active registers stay in seg7_scan_ctrl.

Test Plan:
1. ON_CYC=3, BLANK_CYC=1, no LOAD: release RST -> all enables off at cycle 0; DS_EN1 on cycles 1-3, off at 4; DS_EN2 on 5-7; ...; FRAME high at cycle 16, period 16; segments = 3F.
2. LOAD DATA=16'h12AF at cycle 2 -> PENDING=1 from cycle 3 until the FRAME cycle 16. Next frame shows:
   - DS_EN1 segments 71
   - DS_EN2 segments 77
   - DS_EN3 segments 5B
   - DS_EN4 segments 06
3. LOAD 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed. LOAD coincident with the FRAME edge -> previous shadow commits, PENDING stays 1, and the new value appears one frame later.
4. LZB=1, DATA=16'h0030:
   - DS_EN4 segments off, DS_EN3 segments off.
   - DS_EN2 = 4F, DS_EN1 = 3F.
   - With DATA=0, only DS_EN1 lights, showing 3F.
5. Assert RST while DS_EN3 is on -> all outputs return to their reset values asynchronously; the shadow is cleared; the scan restarts at BLANK/digit 1 after release.
6. EN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1 -> the same timing as scenario 1 with all outputs inverted. In every cycle, at most one enable is asserted.
